// File: rtl/scan_chain_pkg.sv
// Shared types for the scan chain driver: FSM state encoding and small helpers.
package scan_chain_pkg;

  localparam int StateW = 3;

  typedef enum logic [StateW-1:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PHN   = 3'd2,
    GAP1  = 3'd3,
    PHP   = 3'd4,
    GAP2  = 3'd5,
    FIN   = 3'd6
  } scan_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Phase timing for one scan pulse pair: times each pulse/gap state and drives
// the registered SClkN/SClkP pulses from the upcoming FSM state.
module scan_phase_gen
  import scan_chain_pkg::*;
#(
  parameter int ClkDiv    = 2,
  parameter int GapCycles = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  scan_state_e state,
  input  scan_state_e state_nxt,
  output logic        phase_last,
  output logic        pair_done,
  output logic        sclkn,
  output logic        sclkp
);

  localparam int CntW = $clog2(max2(ClkDiv, GapCycles) + 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(ClkDiv - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GapCycles - 1);

  logic [CntW-1:0] cnt;

  // Single-cycle states (SETUP, IDLE, FIN) always report their last cycle.
  always_comb begin
    case (state)
      PHN, PHP:   phase_last = (cnt == PulseLast);
      GAP1, GAP2: phase_last = (cnt == GapLast);
      default:    phase_last = 1'b1;
    endcase
  end

  assign pair_done = (state == GAP2) && phase_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sclkn <= 1'b0;
      sclkp <= 1'b0;
    end else begin
      cnt   <= phase_last ? '0 : cnt + CntW'(1);
      sclkn <= (state_nxt == PHN);
      sclkp <= (state_nxt == PHP);
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// Scan chain master: optional capture pulse then ChainLength serial shifts, MSB first.
// Define SCAN_READBACK_EN to build the SOut sampling path and the RxData register.
module scan_chain_driver
  import scan_chain_pkg::*;
#(
  parameter int ChainLength = 8,
  parameter int ClkDiv      = 2,
  parameter int GapCycles   = 1,
  parameter int TwoPhase    = 1
) (
  input  logic                   Clk,
  input  logic                   ResetN,
  input  logic                   Start,
  input  logic                   Capture,
  input  logic [ChainLength-1:0] TxData,
  output logic                   Busy,
  output logic                   Done,
  output logic [ChainLength-1:0] RxData,
  output logic                   SClkP,
  output logic                   SClkN,
  output logic                   SEnable,
  output logic                   SIn,
  input  logic                   SOut
);

  localparam int BitW = $clog2(ChainLength + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(ChainLength);
  localparam bit UseN = (TwoPhase != 0);

  scan_state_e state, state_nxt;
  logic phase_last, pair_done, pair_end;
  logic accept;
  logic cap_q;
  logic [BitW-1:0] bit_cnt;
  logic [ChainLength-1:0] tx_sr;
  logic busy_d, done_d, sen_d, sin_d;

  assign accept   = (state == IDLE) && Start;
  assign pair_end = (state == PHP) && phase_last;

  scan_phase_gen #(
    .ClkDiv    (ClkDiv),
    .GapCycles (GapCycles)
  ) u_phase (
    .clk        (Clk),
    .rst_n      (ResetN),
    .state      (state),
    .state_nxt  (state_nxt),
    .phase_last (phase_last),
    .pair_done  (pair_done),
    .sclkn      (SClkN),
    .sclkp      (SClkP)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SETUP;
      SETUP:   state_nxt = UseN ? PHN : PHP;
      PHN:     if (phase_last) state_nxt = GAP1;
      GAP1:    if (phase_last) state_nxt = PHP;
      PHP:     if (phase_last) state_nxt = GAP2;
      GAP2:    if (pair_done) state_nxt = (bit_cnt == BitLast) ? FIN : SETUP;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan data is only ever updated on entry to SETUP, while both scan clocks are low.
  always_comb begin
    busy_d = (state_nxt != IDLE);
    done_d = (state == FIN);
    sen_d  = SEnable;
    sin_d  = SIn;
    if (state_nxt == SETUP) begin
      if (state == IDLE) begin
        sen_d = ~Capture;
        sin_d = ~Capture & TxData[ChainLength-1];
      end else begin
        sen_d = ~cap_q;
        sin_d = ~cap_q & tx_sr[ChainLength-1];
      end
    end else if (state_nxt == FIN || state_nxt == IDLE) begin
      sen_d = 1'b0;
      sin_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      SEnable <= 1'b0;
      SIn     <= 1'b0;
      cap_q   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      Busy    <= busy_d;
      Done    <= done_d;
      SEnable <= sen_d;
      SIn     <= sin_d;
      if (accept) begin
        cap_q   <= Capture;
        bit_cnt <= '0;
      end else if (pair_end) begin
        if (cap_q) cap_q <= 1'b0;
        else       bit_cnt <= bit_cnt + BitW'(1);
      end
    end
  end

  // Next bit to shift always sits in the MSB; advanced after the slave pulse.
  always_ff @(posedge Clk) begin
    if (accept)                 tx_sr <= TxData;
    else if (pair_end && !cap_q) tx_sr <= tx_sr << 1;
  end

`ifdef SCAN_READBACK_EN
  logic [ChainLength-1:0] rx_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)                        rx_q <= '0;
    else if (state == SETUP && SEnable) rx_q <= (rx_q << 1) | ChainLength'(SOut);
  end

  assign RxData = rx_q;
`else
  logic unused_sout;
  assign unused_sout = SOut;
  assign RxData      = '0;
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver driving one 8-bit two-phase read segment.
`timescale 1ns/1ps
module tb_scan_chain_driver;

  localparam int N  = 8;
  localparam int CD = 2;
  localparam int G  = 1;
  localparam int TP = 1;
  localparam int P  = (TP != 0) ? (1 + 2*CD + 2*G) : (1 + CD + G);
`ifdef SCAN_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic Clk = 1'b0, ResetN = 1'b1, Start = 1'b0, Capture = 1'b0;
  logic [N-1:0] TxData = '0;
  logic Busy, Done, SClkP, SClkN, SEnable, SIn, SOut;
  logic [N-1:0] RxData;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  scan_chain_driver #(
    .ChainLength (N),
    .ClkDiv      (CD),
    .GapCycles   (G),
    .TwoPhase    (TP)
  ) dut (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .Start   (Start),
    .Capture (Capture),
    .TxData  (TxData),
    .Busy    (Busy),
    .Done    (Done),
    .RxData  (RxData),
    .SClkP   (SClkP),
    .SClkN   (SClkN),
    .SEnable (SEnable),
    .SIn     (SIn),
    .SOut    (SOut)
  );

  // Two-phase read segment: master stage on SClkN, slave (Q) on SClkP.
  logic [N-1:0] seg_q = '0, seg_m = '0, cfg_in = '0;
  always @(posedge SClkN) seg_m = SEnable ? {seg_q[N-2:0], SIn} : cfg_in;
  always @(posedge SClkP) seg_q = seg_m;
  assign SOut = seg_q[N-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is (N+cap) pairs of P cycles, one FIN cycle, then Done.
  int cyc = 0, acc = -100000, m_len = 0;
  logic m_act = 1'b0, m_cap = 1'b0;
  logic [N-1:0] m_tx = '0, m_rx = '0;

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      m_act = 1'b0;
    end else begin
      if (!(m_act && (cyc - acc) <= m_len) && Start) begin
        m_act = 1'b1;
        m_cap = Capture;
        m_tx  = TxData;
        m_len = (N + int'(Capture)) * P;
        m_rx  = RB ? (Capture ? cfg_in : seg_q) : '0;
        acc   = cyc + 1;
      end
      cyc++;
    end
  end

  int c_k, c_j, c_p, c_s;
  logic eb, ed, en, ep, ee, ei;
  logic prev_sen = 1'b0, prev_sin = 1'b0, prev_clk = 1'b0, prev_rst = 1'b0;

  always @(negedge Clk) begin
    c_k = cyc - acc;
    eb = 0; ed = 0; en = 0; ep = 0; ee = 0; ei = 0;
    if (m_act && c_k >= 0 && c_k < m_len) begin
      c_j = c_k / P;
      c_p = c_k % P;
      eb  = 1;
      if (TP != 0) begin
        en = (c_p >= 1) && (c_p <= CD);
        ep = (c_p >= 1 + CD + G) && (c_p <= 2*CD + G);
      end else begin
        ep = (c_p >= 1) && (c_p <= CD);
      end
      if (!(m_cap && c_j == 0)) begin
        c_s = c_j - int'(m_cap);
        ee  = 1;
        ei  = m_tx[N-1-c_s];
      end
    end else if (m_act && c_k == m_len) begin
      eb = 1;
    end else if (m_act && c_k == m_len + 1) begin
      ed = 1;
    end
    check("busy", Busy, eb);
    check("done", Done, ed);
    check("sclkn", SClkN, en);
    check("sclkp", SClkP, ep);
    check("senable", SEnable, ee);
    check("sin", SIn, ei);
    check("no_overlap", SClkN & SClkP, 1'b0);
    if (ResetN && prev_rst && (SEnable !== prev_sen || SIn !== prev_sin))
      check("data_change_clocks_low", {prev_clk, SClkN | SClkP}, 2'b00);
    if (ed) begin
      check("rxdata_at_done", RxData, m_rx);
      check("segment_q_at_done", seg_q, m_tx);
    end
    prev_sen = SEnable;
    prev_sin = SIn;
    prev_clk = SClkN | SClkP;
    prev_rst = ResetN;
  end

  // Runs one transaction; optionally pulses Start again while busy at loop index spur.
  task automatic run_txn(input logic cap, input logic [N-1:0] tx, input logic [N-1:0] cfg,
                         input int spur, output int busy_cyc, output int dones);
    cfg_in = cfg;
    @(posedge Clk); #1;
    Start = 1'b1; Capture = cap; TxData = tx;
    @(posedge Clk); #1;
    Start = 1'b0; Capture = 1'($urandom); TxData = N'($urandom);
    busy_cyc = 0;
    dones    = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (Busy) busy_cyc++;
      if (i == spur) begin Start = 1'b1; Capture = 1'($urandom); TxData = N'($urandom); end
      if (i == spur + 1) Start = 1'b0;
      if (Done) begin dones++; break; end
    end
    Start = 1'b0;
    for (int i = 0; i < 2*P; i++) begin
      @(negedge Clk);
      if (Done) dones++;
    end
  endtask

  int bc, dn;
  logic [N-1:0] rtx, rcfg, rx_hold;
  logic rcap;

  initial begin
    // Reset: everything low, and stays low with no Start.
    #2 ResetN = 1'b0;
    #1;
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_clks", {SClkN, SClkP}, 2'b00);
    check("rst_sen_sin", {SEnable, SIn}, 2'b00);
    check("rst_rxdata", RxData, '0);
    repeat (3) @(posedge Clk);
    #1 ResetN = 1'b1;
    repeat (5) @(negedge Clk);
    check("idle_busy", Busy, 1'b0);
    check("idle_outputs", {Done, SClkN, SClkP, SEnable, SIn}, 5'b0);

    // Capture + shift, with a second Start while busy that must be ignored.
    run_txn(1'b1, 8'h3C, 8'hA5, 20, bc, dn);
    check("t2_busy_cycles", bc, 64);
    check("t2_rxdata", RxData, RB ? 8'hA5 : 8'h00);
    check("t2_segment_q", seg_q, 8'h3C);
    check("t4_single_done", dn, 1);
    check("t4_rxdata_held", RxData, RB ? 8'hA5 : 8'h00);

    // Shift-only reads back the previous chain contents.
    run_txn(1'b0, 8'hFF, 8'h00, -10, bc, dn);
    check("t3_busy_cycles", bc, 57);
    check("t3_rxdata", RxData, RB ? 8'h3C : 8'h00);
    check("t3_segment_q", seg_q, 8'hFF);
    check("t3_single_done", dn, 1);

    // Randomized transactions, some with ignored Starts while busy.
    for (int t = 0; t < 8; t++) begin
      rcap = 1'($urandom);
      rtx  = N'($urandom);
      rcfg = N'($urandom);
      run_txn(rcap, rtx, rcfg, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 50)) : -10, bc, dn);
      check("rand_busy_cycles", bc, (N + int'(rcap)) * P + 1);
      check("rand_single_done", dn, 1);
      check("rand_segment_q", seg_q, rtx);
    end

    // Reset in the middle of shifting bit 4: outputs drop at once, no Done.
    cfg_in = 8'h00;
    @(posedge Clk); #1;
    Start = 1'b1; Capture = 1'b0; TxData = 8'h96;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4*P + 2) @(posedge Clk);
    #2;
    check("t6_pre_busy", Busy, 1'b1);
    ResetN = 1'b0;
    #1;
    check("t6_rst_busy", Busy, 1'b0);
    check("t6_rst_outputs", {Done, SClkN, SClkP, SEnable, SIn}, 5'b0);
    dn = 0;
    for (int i = 0; i < 3*P; i++) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    check("t6_no_done", dn, 0);
    #1 ResetN = 1'b1;
    repeat (2) @(negedge Clk);

    run_txn(1'b1, 8'h5A, 8'hC3, -10, bc, dn);
    check("t6_after_busy_cycles", bc, 64);
    check("t6_after_rxdata", RxData, RB ? 8'hC3 : 8'h00);
    check("t6_after_segment_q", seg_q, 8'h5A);
    check("t6_after_single_done", dn, 1);

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
